// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared FSM state encoding and sizing constants for the inference scheduler
// Contents: state_t (scheduler FSM states), STAGE_W (stage index width),
//           TIMEOUT_DEFAULT (default watchdog limit in cycles)
package nn_ctrl_pkg;
    localparam int STAGE_W         = 2;
    localparam int TIMEOUT_DEFAULT = 65535;
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_STREAM      = 3'd1,
        ST_DRAIN       = 3'd2,
        ST_WAIT_RESULT = 3'd3,
        ST_ERR         = 3'd4
    } state_t;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: rising-edge detector for a clk-synchronous level signal
// Ports: clk (rising-edge clock), rst_n (async active-low reset),
//        i_sig (level input), o_rise (combinational pulse on 0->1 of i_sig)
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);
    logic r_prev;
    logic r_armed;
    // r_armed suppresses the first cycle after reset so a level already high
    // when reset releases is not mistaken for an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= i_sig;
            r_armed <= 1'b1;
        end
    end
    assign o_rise = r_armed & i_sig & ~r_prev;
endmodule

// File: rtl/stream_inference_scheduler.sv
// stream_inference_scheduler: sequences one video frame through a layered NN pipeline
// Ports: clk, rst_n (async active-low); VSYNC/HSYNC frame and line syncs;
//        layer_done (per-stage done pulses), result_done/result_in (output layer);
//        clear_err (leaves ERR); frame_start, stream_enable, busy, stage, line_count,
//        result_out/result_valid, frames_dropped, timeout_err (sticky watchdog flag)
module stream_inference_scheduler
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_LAYERS     = 3,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int LINE_W         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  VSYNC,
    input  logic                  HSYNC,
    input  logic [NUM_LAYERS-2:0] layer_done,
    input  logic                  result_done,
    input  logic [3:0]            result_in,
    input  logic                  clear_err,
    output logic                  frame_start,
    output logic                  stream_enable,
    output logic                  busy,
    output logic [STAGE_W-1:0]    stage,
    output logic [LINE_W-1:0]     line_count,
    output logic [3:0]            result_out,
    output logic                  result_valid,
    output logic [15:0]           frames_dropped,
    output logic                  timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                  r_state;
    logic [STAGE_W-1:0]      r_stage;
    logic [WD_W-1:0]         r_wdog;
    logic [LINE_W-1:0]       r_line_count;
    logic                    r_frame_start;
    logic [3:0]              r_result_out;
    logic                    r_result_valid;
    logic [15:0]             r_frames_dropped;
    logic                    r_timeout_err;

    logic                    w_vs_rise;
    logic                    w_hs_rise;
    logic [NUM_LAYERS-2:0]   w_done_mask;
    logic                    w_stage_done;
    logic                    w_running;
    logic                    w_expired;

    sync_edge_detect u_vs (.clk(clk), .rst_n(rst_n), .i_sig(VSYNC), .o_rise(w_vs_rise));
    sync_edge_detect u_hs (.clk(clk), .rst_n(rst_n), .i_sig(HSYNC), .o_rise(w_hs_rise));

    // Only the done bit of the awaited stage is accepted; others are ignored
    assign w_done_mask  = (NUM_LAYERS-1)'(1) << r_stage;
    assign w_stage_done = |(layer_done & w_done_mask);
    assign w_running    = (r_state == ST_STREAM) || (r_state == ST_DRAIN) || (r_state == ST_WAIT_RESULT);
    // Expiry is taken on the edge where the counter would reach the limit
    assign w_expired    = w_running && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_stage          <= '0;
            r_wdog           <= '0;
            r_line_count     <= '0;
            r_frame_start    <= 1'b0;
            r_result_out     <= '0;
            r_result_valid   <= 1'b0;
            r_frames_dropped <= '0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_frame_start  <= 1'b0;
            r_result_valid <= 1'b0;
            r_wdog         <= w_running ? r_wdog + 1'b1 : '0;
            if (w_vs_rise && r_state != ST_IDLE && r_frames_dropped != 16'hFFFF)
                r_frames_dropped <= r_frames_dropped + 1'b1;
            if (w_hs_rise && r_state == ST_STREAM && r_line_count != '1)
                r_line_count <= r_line_count + 1'b1;
            if (w_expired) begin
                r_state       <= ST_ERR;
                r_timeout_err <= 1'b1;
                r_stage       <= '0;
                r_wdog        <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_vs_rise) begin
                        r_state       <= ST_STREAM;
                        r_frame_start <= 1'b1;
                        r_line_count  <= '0;
                        r_wdog        <= '0;
                    end
                    ST_STREAM: if (w_stage_done) begin
                        r_state <= (NUM_LAYERS == 2) ? ST_WAIT_RESULT : ST_DRAIN;
                        r_stage <= STAGE_W'(1);
                        r_wdog  <= '0;
                    end
                    ST_DRAIN: if (w_stage_done) begin
                        r_stage <= r_stage + 1'b1;
                        r_wdog  <= '0;
                        if (r_stage == STAGE_W'(NUM_LAYERS - 2))
                            r_state <= ST_WAIT_RESULT;
                    end
                    ST_WAIT_RESULT: if (result_done) begin
                        r_result_out   <= result_in;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                        r_stage        <= '0;
                        r_wdog         <= '0;
                    end
                    ST_ERR: if (clear_err) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b0;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign frame_start    = r_frame_start;
    assign stream_enable  = (r_state == ST_STREAM);
    assign busy           = (r_state != ST_IDLE);
    assign stage          = (r_state == ST_DRAIN || r_state == ST_WAIT_RESULT) ? r_stage : '0;
    assign line_count     = r_line_count;
    assign result_out     = r_result_out;
    assign result_valid   = r_result_valid;
    assign frames_dropped = r_frames_dropped;
    assign timeout_err    = r_timeout_err;
endmodule
